// File: rtl/pedo_pkg.sv
// Shared pedometer definitions: controller state encodings and result widths.
package pedo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALIB = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } ctrl_state_e;

  localparam int unsigned STEPS_W   = 16;
  localparam int unsigned ELAPSED_W = 16;

  // Bits needed to count 0..limit-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Free-running cycle counter producing a one-cycle tick each time it wraps at CLK_HZ-1.
module sec_tick_gen
  import pedo_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = cnt_width(CLK_HZ);
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_HZ - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = en && !clr && (cnt_q == CntMax);

  // Next count: clear wins, otherwise advance and wrap while enabled, else hold (frozen).
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/step_session_ctrl.sv
// Pedometer session sequencer: calibration, run/pause gating of the step detector,
// per-session step and elapsed-second accounting, and inactivity auto-pause.
module step_session_ctrl
  import pedo_pkg::*;
#(
  parameter int unsigned CLK_HZ             = 100_000_000,
  parameter int unsigned CAL_TIMEOUT_CYCLES = 200_000_000,
  parameter int unsigned IDLE_TIMEOUT_S     = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_btn,
  input  logic                 stop_btn,
  input  logic                 cal_done,
  input  logic                 step_pulse,
  output logic                 cal_start,
  output logic                 det_reset,
  output logic                 det_enable,
  output logic [STEPS_W-1:0]   session_steps,
  output logic [ELAPSED_W-1:0] elapsed_s,
  output logic [1:0]           ctrl_state,
  output logic                 cal_err
);

  localparam int unsigned CalW = cnt_width(CAL_TIMEOUT_CYCLES);
  localparam logic [CalW-1:0] CalLast = CalW'(CAL_TIMEOUT_CYCLES - 1);
  localparam logic [7:0] IdleLimit = (IDLE_TIMEOUT_S > 255) ? 8'hFF : 8'(IDLE_TIMEOUT_S);

  ctrl_state_e          state_q, state_d;
  logic [CalW-1:0]      cal_cnt_q, cal_cnt_d;
  logic [7:0]           inact_q, inact_d;
  logic [STEPS_W-1:0]   steps_q, steps_d;
  logic [ELAPSED_W-1:0] elapsed_q, elapsed_d;
  logic                 cal_err_q, cal_err_d;
  logic                 cal_start_q, cal_start_d;
  logic                 det_reset_q, det_enable_q;
  logic                 tick, tick_en, tick_clr;

  assign tick_en = (state_q == ST_RUN);

  sec_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_sec_tick_gen (
    .clk  (clk),
    .reset(reset),
    .en   (tick_en),
    .clr  (tick_clr),
    .tick (tick)
  );

  // Next-state and counter updates; stop_btn is checked before start_btn everywhere.
  always_comb begin
    state_d     = state_q;
    cal_cnt_d   = cal_cnt_q;
    inact_d     = inact_q;
    steps_d     = steps_q;
    elapsed_d   = elapsed_q;
    cal_err_d   = cal_err_q;
    cal_start_d = 1'b0;
    tick_clr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!stop_btn && start_btn) begin
          state_d     = ST_CALIB;
          cal_start_d = 1'b1;
          steps_d     = '0;
          elapsed_d   = '0;
          cal_err_d   = 1'b0;
          cal_cnt_d   = '0;
        end
      end
      ST_CALIB: begin
        cal_cnt_d = cal_cnt_q + 1'b1;
        if (stop_btn) begin
          state_d = ST_IDLE;
        end else if (cal_done) begin
          state_d  = ST_RUN;
          inact_d  = '0;
          tick_clr = 1'b1;
        end else if (cal_cnt_q == CalLast) begin
          state_d   = ST_IDLE;
          cal_err_d = 1'b1;
        end
      end
      ST_RUN: begin
        // Accounting happens even on the cycle we leave RUN.
        if (step_pulse) begin
          steps_d = (steps_q == '1) ? steps_q : steps_q + 1'b1;
          inact_d = '0;
        end else if (tick) begin
          inact_d = (inact_q == 8'hFF) ? inact_q : inact_q + 8'd1;
        end
        if (tick) begin
          elapsed_d = (elapsed_q == '1) ? elapsed_q : elapsed_q + 1'b1;
        end
        if (stop_btn) begin
          state_d = ST_IDLE;
        end else if (start_btn || (inact_d >= IdleLimit)) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (stop_btn) begin
          state_d = ST_IDLE;
        end else if (start_btn) begin
          state_d = ST_RUN;
          inact_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs; detector controls track the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cal_cnt_q    <= '0;
      inact_q      <= '0;
      steps_q      <= '0;
      elapsed_q    <= '0;
      cal_err_q    <= 1'b0;
      cal_start_q  <= 1'b0;
      det_reset_q  <= 1'b1;
      det_enable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cal_cnt_q    <= cal_cnt_d;
      inact_q      <= inact_d;
      steps_q      <= steps_d;
      elapsed_q    <= elapsed_d;
      cal_err_q    <= cal_err_d;
      cal_start_q  <= cal_start_d;
      det_reset_q  <= (state_d == ST_IDLE) || (state_d == ST_CALIB);
      det_enable_q <= (state_d == ST_RUN);
    end
  end

  assign cal_start     = cal_start_q;
  assign det_reset     = det_reset_q;
  assign det_enable    = det_enable_q;
  assign session_steps = steps_q;
  assign elapsed_s     = elapsed_q;
  assign ctrl_state    = state_q;
  assign cal_err       = cal_err_q;

endmodule

// File: tb/tb_step_session_ctrl.sv
// Self-checking bench for step_session_ctrl with CLK_HZ=10, CAL_TIMEOUT_CYCLES=20,
// IDLE_TIMEOUT_S=3.
module tb_step_session_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_btn, stop_btn, cal_done, step_pulse;
  logic        cal_start, det_reset, det_enable, cal_err;
  logic [15:0] session_steps, elapsed_s;
  logic [1:0]  ctrl_state;

  int n_asserts = 0;
  int n_fail    = 0;

  typedef struct {
    logic        start, stop, cal, step;
    int          rep;
    logic [1:0]  st;
    logic        cs, dr, de, ce;
    logic [15:0] steps, el;
  } vec_t;

  typedef struct {
    string       tag;
    logic [1:0]  st;
    logic        cs, dr, de, ce;
    logic [15:0] steps, el;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];

  step_session_ctrl #(
    .CLK_HZ            (10),
    .CAL_TIMEOUT_CYCLES(20),
    .IDLE_TIMEOUT_S    (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_btn    (start_btn),
    .stop_btn     (stop_btn),
    .cal_done     (cal_done),
    .step_pulse   (step_pulse),
    .cal_start    (cal_start),
    .det_reset    (det_reset),
    .det_enable   (det_enable),
    .session_steps(session_steps),
    .elapsed_s    (elapsed_s),
    .ctrl_state   (ctrl_state),
    .cal_err      (cal_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, p, c, k, input int rep, input logic [1:0] st,
                              input logic cs, dr, de, ce, input logic [15:0] steps, el);
    vec_t v;
    v.start = s; v.stop = p; v.cal = c; v.step = k; v.rep = rep;
    v.st = st; v.cs = cs; v.dr = dr; v.de = de; v.ce = ce; v.steps = steps; v.el = el;
    return v;
  endfunction

  task automatic push_exp(input string tag, input logic [1:0] st, input logic cs, dr, de, ce,
                          input logic [15:0] steps, el);
    exp_t e;
    e.tag = tag; e.st = st; e.cs = cs; e.dr = dr; e.de = de; e.ce = ce;
    e.steps = steps; e.el = el;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    n_asserts++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h, expected %0h", tag, fld, act, req);
    end
  endtask

  task automatic compare_pop();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_asserts++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = exp_q.pop_front();
    chk(e.tag, "ctrl_state", 32'(ctrl_state), 32'(e.st));
    chk(e.tag, "cal_start", 32'(cal_start), 32'(e.cs));
    chk(e.tag, "det_reset", 32'(det_reset), 32'(e.dr));
    chk(e.tag, "det_enable", 32'(det_enable), 32'(e.de));
    chk(e.tag, "cal_err", 32'(cal_err), 32'(e.ce));
    chk(e.tag, "session_steps", 32'(session_steps), 32'(e.steps));
    chk(e.tag, "elapsed_s", 32'(elapsed_s), 32'(e.el));
  endtask

  task automatic drive(input logic s, p, c, k);
    start_btn = s; stop_btn = p; cal_done = c; step_pulse = k;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Columns: start stop cal step rep | st cs dr de ce steps el
    // Tests 1-3: start, calibrate, count steps, elapsed, auto-pause, resume.
    tbl.push_back(mk(1, 0, 0, 0, 1,  2'd1, 1, 1, 0, 0, 16'd0, 16'd0));
    tbl.push_back(mk(0, 0, 0, 0, 1,  2'd1, 0, 1, 0, 0, 16'd0, 16'd0));
    tbl.push_back(mk(0, 0, 0, 0, 3,  2'd1, 0, 1, 0, 0, 16'd0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 0, 1,  2'd2, 0, 0, 1, 0, 16'd0, 16'd0));
    tbl.push_back(mk(0, 0, 0, 1, 1,  2'd2, 0, 0, 1, 0, 16'd1, 16'd0));
    tbl.push_back(mk(0, 0, 0, 0, 7,  2'd2, 0, 0, 1, 0, 16'd1, 16'd0));
    tbl.push_back(mk(0, 0, 0, 1, 1,  2'd2, 0, 0, 1, 0, 16'd2, 16'd0));
    tbl.push_back(mk(0, 0, 0, 0, 7,  2'd2, 0, 0, 1, 0, 16'd2, 16'd1));
    tbl.push_back(mk(0, 0, 0, 1, 1,  2'd2, 0, 0, 1, 0, 16'd3, 16'd1));
    tbl.push_back(mk(0, 0, 0, 0, 7,  2'd2, 0, 0, 1, 0, 16'd3, 16'd2));
    tbl.push_back(mk(0, 0, 0, 1, 1,  2'd2, 0, 0, 1, 0, 16'd4, 16'd2));
    tbl.push_back(mk(0, 0, 0, 0, 5,  2'd2, 0, 0, 1, 0, 16'd4, 16'd3));
    tbl.push_back(mk(0, 0, 0, 0, 19, 2'd2, 0, 0, 1, 0, 16'd4, 16'd4));
    tbl.push_back(mk(0, 0, 0, 0, 1,  2'd3, 0, 0, 0, 0, 16'd4, 16'd5));
    tbl.push_back(mk(0, 0, 0, 1, 1,  2'd3, 0, 0, 0, 0, 16'd4, 16'd5));
    tbl.push_back(mk(0, 0, 0, 0, 3,  2'd3, 0, 0, 0, 0, 16'd4, 16'd5));
    tbl.push_back(mk(1, 0, 0, 0, 1,  2'd2, 0, 0, 1, 0, 16'd4, 16'd5));
    // Test 5: start+stop in RUN, results held in IDLE.
    tbl.push_back(mk(1, 1, 0, 0, 1,  2'd0, 0, 1, 0, 0, 16'd4, 16'd5));
    tbl.push_back(mk(0, 0, 0, 0, 2,  2'd0, 0, 1, 0, 0, 16'd4, 16'd5));
    // Test 4: calibration timeout, then cal_err cleared by next start.
    tbl.push_back(mk(1, 0, 0, 0, 1,  2'd1, 1, 1, 0, 0, 16'd0, 16'd0));
    tbl.push_back(mk(0, 0, 0, 0, 18, 2'd1, 0, 1, 0, 0, 16'd0, 16'd0));
    tbl.push_back(mk(0, 0, 0, 0, 1,  2'd1, 0, 1, 0, 0, 16'd0, 16'd0));
    tbl.push_back(mk(0, 0, 0, 0, 1,  2'd0, 0, 1, 0, 1, 16'd0, 16'd0));
    tbl.push_back(mk(1, 0, 0, 0, 1,  2'd1, 1, 1, 0, 0, 16'd0, 16'd0));
    // Stop in CALIB; start+stop in IDLE does nothing.
    tbl.push_back(mk(0, 1, 0, 0, 1,  2'd0, 0, 1, 0, 0, 16'd0, 16'd0));
    tbl.push_back(mk(1, 1, 0, 0, 1,  2'd0, 0, 1, 0, 0, 16'd0, 16'd0));
    // cal_done on the timeout cycle wins.
    tbl.push_back(mk(1, 0, 0, 0, 1,  2'd1, 1, 1, 0, 0, 16'd0, 16'd0));
    tbl.push_back(mk(0, 0, 0, 0, 19, 2'd1, 0, 1, 0, 0, 16'd0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 0, 1,  2'd2, 0, 0, 1, 0, 16'd0, 16'd0));

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    push_exp("reset", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    compare_pop();
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].start, tbl[i].stop, tbl[i].cal, tbl[i].step);
      push_exp($sformatf("vec%0d", i), tbl[i].st, tbl[i].cs, tbl[i].dr, tbl[i].de, tbl[i].ce,
               tbl[i].steps, tbl[i].el);
      for (int r = 0; r < tbl[i].rep; r++) cycle();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      compare_pop();
    end

    // Test 6: step every RUN cycle up to and past saturation; tick every 10 cycles.
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    push_exp("sat_fffe", 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFE, 16'd6553);
    for (int n = 0; n < 65534; n++) cycle();
    compare_pop();
    push_exp("sat_ffff", 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'd6553);
    cycle();
    compare_pop();
    push_exp("sat_hold", 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'd6553);
    cycle();
    cycle();
    compare_pop();

    // Reset mid-RUN with buttons active: reset values, and no cal_start afterwards.
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    push_exp("rst_mid", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    cycle();
    compare_pop();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    push_exp("rst_after", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    cycle();
    compare_pop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
